// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (adds the HALT state and illegal_op output).
package mips_pkg;

    // FSM states; HALT exists only when illegal-op trapping is built in.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ      = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        JUMP     = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        HALT     = 4'd12
`endif
    } state_t;

    // Opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction bits [5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl codes.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp from the FSM to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB encodings.
    localparam logic [2-1:0] SRCB_REG     = 2'b00;
    localparam logic [2-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [2-1:0] SRCB_IMM     = 2'b10;
    localparam logic [2-1:0] SRCB_IMM_SH2 = 2'b11;

    // PCSource encodings.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and funct onto ALUControl.
// Unlisted funct codes decode to ADD and raise unknown_funct.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       unknown_funct
);

    // Select the ALU operation; funct only matters for funct-driven ALUOp.
    always_comb begin
        alucontrol    = ALU_ADD;
        unknown_funct = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: begin
                        alucontrol    = ALU_ADD;
                        unknown_funct = 1'b1;
                    end
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional feature macro: ILLEGAL_OP_TRAP_EN -- unlisted opcode/funct traps into
// HALT and drives illegal_op; otherwise they behave as NOP / ADD respectively.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSource,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       retire
);

    state_t     state_r;
    state_t     next_state_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       retire_s;
    logic [1:0] aluop_s;
    logic       unknown_funct_s;

    alu_decoder u_alu_decoder (
        .aluop         (aluop_s),
        .funct         (funct),
        .alucontrol    (ALUControl),
        .unknown_funct (unknown_funct_s)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        next_state_s = state_r;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        IorD         = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        PCSource     = PCSRC_ALU;
        aluop_s      = ALUOP_ADD;
        retire_s     = 1'b0;
        case (state_r)
            FETCH: begin
                mem_read_s   = 1'b1;
                ir_write_s   = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                pcwrite_s    = 1'b1;
                next_state_s = DECODE;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut while dispatching.
                ALUSrcB = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = RTYPE_EX;
                    OP_BEQ:       next_state_s = BEQ;
                    OP_ADDI:      next_state_s = ADDI_EX;
                    OP_J:         next_state_s = JUMP;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        next_state_s = HALT;
`else
                        // Unknown opcode completes as a NOP.
                        next_state_s = FETCH;
                        retire_s     = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_LW) begin
                    next_state_s = MEMRD;
                end else begin
                    next_state_s = MEMWR;
                end
            end
            MEMRD: begin
                IorD         = 1'b1;
                mem_read_s   = 1'b1;
                next_state_s = MEMWB;
            end
            MEMWB: begin
                reg_write_s  = 1'b1;
                MemtoReg     = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            MEMWR: begin
                IorD         = 1'b1;
                mem_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            RTYPE_EX: begin
                ALUSrcA = 1'b1;
                aluop_s = ALUOP_FUNCT;
`ifdef ILLEGAL_OP_TRAP_EN
                if (unknown_funct_s) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = RTYPE_WB;
                end
`else
                next_state_s = RTYPE_WB;
`endif
            end
            RTYPE_WB: begin
                reg_write_s  = 1'b1;
                RegDst       = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            BEQ: begin
                ALUSrcA      = 1'b1;
                aluop_s      = ALUOP_SUB;
                branch_s     = 1'b1;
                PCSource     = PCSRC_ALUOUT;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            ADDI_EX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                next_state_s = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            JUMP: begin
                pcwrite_s    = 1'b1;
                PCSource     = PCSRC_JUMP;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            HALT: begin
                // Parked until reset; no enables, no retire.
                next_state_s = HALT;
            end
`endif
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Write enables and retire are suppressed for the whole reset cycle so
    // an aborted instruction commits nothing.
    assign PCEn     = (pcwrite_s | (branch_s & Zero)) & ~reset;
    assign MemRead  = mem_read_s  & ~reset;
    assign MemWrite = mem_write_s & ~reset;
    assign IRWrite  = ir_write_s  & ~reset;
    assign RegWrite = reg_write_s & ~reset;
    assign retire   = retire_s    & ~reset;

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = (state_r == HALT) & ~reset;
`else
    // The decoder flag has no consumer when unknown funct simply executes as ADD.
    logic unused_s;
    assign unused_s = unknown_funct_s;
`endif

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit that drives the ALU's operation and operand-select inputs and consumes its `Zero` flag. It is a Moore FSM that sequences each instruction through FETCH, DECODE, execute and writeback. It produces every datapath enable, including `ALUControl` and the operand muxes, and it evaluates branches from `Zero`. It sits between the instruction register and the shared datapath of the multicycle MIPS core.

## Interface
- `RESET_STATE`, default FETCH: state entered on reset. Fixed; exposed for bench visibility only.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 6: instruction bits [31:26] from the instruction register.
- `funct` input 6: instruction bits [5:0].
- `Zero` input 1: ALU zero flag, combinational in the current cycle.
- `PCEn` output 1: PC write enable, equal to `PCWrite | (Branch & Zero)`.
- `IorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite` outputs, 1 bit each: datapath enables.
- `MemtoReg` output 1: writeback data select; 1 = memory data register.
- `RegDst` output 1: destination register select; 1 = rd, 0 = rt.
- `ALUSrcA` output 1: 0 = PC, 1 = register A.
- `ALUSrcB` output 2: 00 = register B; 01 = constant 4; 10 = sign-extended immediate; 11 = sign-extended immediate << 2.
- `ALUControl` output 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `PCSource` output 2: 00 = ALU result; 01 = ALUOut; 10 = jump target.
- `retire` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` output 1: present only with the trap option (see Configuration).

## Operation
- States:
  - FETCH: MemRead, IRWrite, ALUSrcA=0, ALUSrcB=01, ADD, PCWrite, PCSource=00.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD.
  - MEMRD: IorD=1, MemRead.
  - MEMWB: RegWrite, MemtoReg=1, RegDst=0.
  - MEMWR: IorD=1, MemWrite.
  - RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUControl from funct.
  - RTYPE_WB: RegWrite, RegDst=1, MemtoReg=0.
  - BEQ: ALUSrcA=1, ALUSrcB=00, SUB, Branch, PCSource=01.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ADD.
  - ADDI_WB: RegWrite, RegDst=0, MemtoReg=0.
  - JUMP: PCWrite, PCSource=10.
- Transitions:
  - FETCH → DECODE.
  - DECODE dispatches on opcode: 100011 lw and 101011 sw → MEMADR; 000000 → RTYPE_EX; 000100 → BEQ; 001000 → ADDI_EX; 000010 → JUMP.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - RTYPE_EX → RTYPE_WB; ADDI_EX → ADDI_WB.
  - MEMWB, MEMWR, RTYPE_WB, ADDI_WB, BEQ, JUMP → FETCH.
- funct decode: 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001; 101010 → 111.
- Unlisted opcode or funct: handling is set by the configuration option.
- Any state that does not name a signal drives it to 0. `ALUControl` defaults to 010 and the two-bit selects default to 00.
- `retire` is high in MEMWB, MEMWR, RTYPE_WB, ADDI_WB, BEQ and JUMP.

## Timing
- Outputs are combinational from the state register. `PCEn` additionally depends on `Zero` in the same cycle.
- Latency in cycles, including FETCH: lw 5; sw, R-type and addi 4; beq and j 3.
- `opcode` and `funct` are sampled only in DECODE and in the dispatch states. They must stay stable from the cycle after FETCH until `retire`.
- Reset:
  - While `reset` is high, PCEn, MemRead, MemWrite, IRWrite, RegWrite, retire and illegal_op are forced to 0.
  - At the next clock edge the state becomes FETCH, whatever the current state.
  - Reset asserted mid-instruction aborts it with no further writes.
- `Zero` is ignored in every state except BEQ.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined:
  - An unlisted opcode in DECODE, or an unlisted funct in RTYPE_EX, moves the FSM to HALT.
  - HALT asserts no enables, leaves `retire` low, holds `illegal_op` high, and stays in HALT until `reset`.
- `ILLEGAL_OP_TRAP_EN` undefined:
  - There is no HALT state and no `illegal_op` port.
  - An unlisted opcode returns DECODE to FETCH with `retire` pulsed, i.e. the instruction acts as a NOP.
  - An unlisted funct executes as ADD and writes back normally.

## Structure
- Package `mips_pkg` holds:
  - the state enum;
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct localparams;
  - ALUControl code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - ALUSrcB and PCSource encodings.
- Sub-module `alu_decoder`: combinational. Inputs are a 2-bit ALUOp (00 ADD, 01 SUB, 10 funct-driven) and funct. Outputs are `ALUControl` and an `unknown_funct` flag.

## Test plan
- lw (opcode 100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `retire` pulses in cycle 5. In MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- R-type, funct 101010: `ALUControl`=111 in RTYPE_EX. In RTYPE_WB: RegWrite=1, RegDst=1. Total 4 cycles.
- beq with `Zero`=1: PCEn=1 and PCSource=01 in cycle 3. Repeat with `Zero`=0: PCEn=0. Both return to FETCH.
- j (opcode 000010): PCEn=1 and PCSource=10 in cycle 3. `Zero` toggling has no effect.
- `reset` asserted during MEMRD: enables read 0 that cycle, and state is FETCH after the edge.
- Opcode 111111:
  - With `ILLEGAL_OP_TRAP_EN`: enters HALT; `illegal_op`=1 and persists for 10 cycles; cleared by `reset`.
  - Without it: returns to FETCH with `retire`=1 in cycle 2.
